pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch over a req/ack imem handshake.
//  Selects next PC by priority: exception > redirect (branch/jump) > sequential PC+4.
//  Stalls on decode backpressure and discards in-flight fetches killed by a redirect.
//  Sits between the PC register and the IF/ID boundary.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on rst
//  EXC_VECTOR    32'h0000_0080  PC loaded on exc_valid
//  ACK_TIMEOUT   16             cycles a req may wait for ack before fetch_timeout sets
// PORTS
//  clk             in   1       single clock, all state updates on posedge
//  rst             in   1       synchronous, active-high reset
//  stall           in   1       decode cannot accept an instruction this cycle
//  redirect_valid  in   1       branch/jump taken; one-cycle pulse
//  redirect_pc     in   `N+1    redirect target; bits [1:0] forced to 0
//  exc_valid       in   1       exception; one-cycle pulse; target EXC_VECTOR
//  imem_req        out  1       fetch request; address must stay stable until imem_ack
//  imem_addr       out  `N+1    fetch address
//  imem_ack        in   1       fetch data valid this cycle; meaningful only while imem_req=1
//  if_valid        out  1       instruction at if_pc is valid for decode
//  if_pc           out  `N+1    PC of the instruction offered to decode
//  pc              out  `N+1    current PC register
//  pc_next         out  `N+1    pc+4, modulo 2^(`N+1)
//  fetch_timeout   out  1       sticky: req waited ACK_TIMEOUT cycles without ack
// BEHAVIOUR
//  Reset: pc=RESET_VECTOR, state=BOOT, imem_req=0, if_valid=0, fetch_timeout=0, wait_cnt=0.
//  rst dominates all other inputs in any state; a mid-fetch req is abandoned without waiting for ack.
//  States:
//  - BOOT: outputs idle; next state REQ (one cycle, unconditional).
//  - REQ: imem_req=1, imem_addr=pc.
//  - HOLD: imem_req=0, if_valid=1, if_pc=pc; the acked instruction is held.
//  - DROP: imem_req=1, imem_addr=old pc, if_valid=0; the returning ack is discarded.
//  kill = exc_valid | redirect_valid; tgt = exc_valid ? EXC_VECTOR : {redirect_pc[`N:2],2'b00}.
//  REQ:
//  - if_valid = imem_ack & ~kill.
//  - kill & imem_ack: pc<=tgt, stay REQ.
//  - kill & ~imem_ack: save tgt, go DROP.
//  - ack & ~stall: pc<=pc+4, stay REQ; back-to-back fetch, 1 instr/cycle max.
//  - ack & stall: go HOLD; pc unchanged.
//  HOLD:
//  - kill: pc<=tgt, go REQ; held instruction dropped.
//  - ~stall: pc<=pc+4, go REQ.
//  - else stay HOLD.
//  DROP:
//  - kill: overwrite saved target (latest wins).
//  - imem_ack: pc<=saved target (or tgt if kill this cycle), go REQ.
//  Exception and redirect in the same cycle: EXC_VECTOR wins.
//  Latency: if_valid is combinational from imem_ack (0 cycles); the next req issues the cycle after acceptance.
//  wait_cnt: counts cycles with imem_req & ~imem_ack; cleared on ack.
//  - wait_cnt==ACK_TIMEOUT-1 with no ack sets fetch_timeout; it stays set until rst.
//  - Counter saturates; the FSM keeps waiting.
//  pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
// STRUCTURE
//  Shared defs (define.v): `N, RESET_VECTOR/EXC_VECTOR defaults, state encodings
//  BOOT=2'd0 REQ=2'd1 HOLD=2'd2 DROP=2'd3.
//  Sub-module pc_reg: `N+1-bit register with sync rst to RESET_VECTOR and load enable;
//  the FSM drives its load/data.
//  FSM, wait_cnt and next-PC mux are in this module.
// TESTING
//  1. Reset, then imem_ack=1 each cycle with stall=0 -> BOOT 1 cycle; imem_addr 0,4,8,C; if_valid high each ack.
//  2. Ack at 0x8 with stall=1 for 3 cycles -> HOLD, if_pc=0x8, imem_req=0 for 3 cycles; next req addr 0xC.
//  3. req at 0x10, no ack; redirect_pc=0x43 -> DROP; ack 2 cycles later gives if_valid=0; next req addr 0x40.
//  4. exc_valid and redirect_valid (0x200) in the same REQ+ack cycle -> if_valid=0; next req addr 0x80.
//  5. pc=0xFFFF_FFFC acked, stall=0 -> next imem_addr 0x0.
//  6. No ack for 16 cycles -> fetch_timeout=1 and stays set after a late ack; rst mid-DROP -> BOOT, pc=0, timeout=0.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer: address width, default vectors,
// ack timeout and fetch FSM state encoding.
package pc_fetch_sequencer_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF   = 32'h0000_0080;
  localparam int unsigned       ACK_TIMEOUT_DEF  = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  // Redirect targets are word aligned; the low two bits are discarded.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_reg.sv
// Program counter register with synchronous reset to the reset vector and a load enable.
module pc_fetch_sequencer_pc_reg
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VALUE = RESET_VECTOR_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_VALUE;
    end else if (load_i) begin
      pc_q <= data_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the PC and sequences instruction fetch over a req/ack imem handshake,
// with exception/redirect priority, decode backpressure and killed-fetch discard.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned       ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              exc_valid_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              fetch_timeout_o
);

  localparam int unsigned     CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              fetch_timeout_q;

  logic              kill;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_d;

  assign kill   = exc_valid_i | redirect_valid_i;
  assign tgt    = exc_valid_i ? EXC_VECTOR : word_align(redirect_pc_i);
  assign pc_inc = pc + ADDR_W'(4);

  pc_fetch_sequencer_pc_reg #(
    .RESET_VALUE(RESET_VECTOR)
  ) u_pc_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(pc_load),
    .data_i(pc_d),
    .pc_o  (pc)
  );

  // Next-PC mux: exception > redirect > sequential.
  always_comb begin
    pc_load = 1'b0;
    pc_d    = pc_inc;
    unique case (state_q)
      REQ: begin
        if (kill && imem_ack_i) begin
          pc_load = 1'b1;
          pc_d    = tgt;
        end else if (imem_ack_i && !stall_i) begin
          pc_load = 1'b1;
        end
      end
      HOLD: begin
        if (kill) begin
          pc_load = 1'b1;
          pc_d    = tgt;
        end else if (!stall_i) begin
          pc_load = 1'b1;
        end
      end
      DROP: begin
        if (imem_ack_i) begin
          pc_load = 1'b1;
          pc_d    = kill ? tgt : tgt_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= BOOT;
      tgt_q           <= RESET_VECTOR;
      wait_cnt_q      <= '0;
      fetch_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: state_q <= REQ;
        REQ: begin
          if (kill && !imem_ack_i) begin
            tgt_q   <= tgt;
            state_q <= DROP;
          end else if (!kill && imem_ack_i && stall_i) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (kill || !stall_i) state_q <= REQ;
        end
        DROP: begin
          if (imem_ack_i) begin
            state_q <= REQ;
          end else if (kill) begin
            tgt_q <= tgt;
          end
        end
        default: state_q <= BOOT;
      endcase

      // Ack wait counter saturates; timeout is sticky until reset.
      if (imem_req_o && imem_ack_i) begin
        wait_cnt_q <= '0;
      end else if (imem_req_o) begin
        if (wait_cnt_q == CNT_MAX) begin
          fetch_timeout_q <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign imem_req_o      = (state_q == REQ) || (state_q == DROP);
  assign imem_addr_o     = pc;
  assign if_valid_o      = (state_q == HOLD) || ((state_q == REQ) && imem_ack_i && !kill);
  assign if_pc_o         = pc;
  assign pc_o            = pc;
  assign pc_next_o       = pc_inc;
  assign fetch_timeout_o = fetch_timeout_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus randomized traffic against a
// behavioural fetch model.
module tb_pc_fetch_sequencer;

  localparam int unsigned ACK_TO = 16;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, exc_valid, imem_ack;
  logic [31:0] redirect_pc;
  logic        imem_req, if_valid, fetch_timeout;
  logic [31:0] imem_addr, if_pc, pc, pc_next;

  int total = 0;
  int bad   = 0;

  // Behavioural model: what the fetch unit is doing, not how it is encoded.
  logic [31:0] m_pc, m_tgt;
  bit          m_boot, m_held, m_drop, m_to;
  int          m_wait;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .exc_valid_i     (exc_valid),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .if_valid_o      (if_valid),
    .if_pc_o         (if_pc),
    .pc_o            (pc),
    .pc_next_o       (pc_next),
    .fetch_timeout_o (fetch_timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc   = 32'h0;
    m_tgt  = 32'h0;
    m_boot = 1'b1;
    m_held = 1'b0;
    m_drop = 1'b0;
    m_to   = 1'b0;
    m_wait = 0;
  endfunction

  task automatic compare_model();
    bit kill, exp_req, exp_ifv;
    kill    = exc_valid | redirect_valid;
    exp_req = !m_boot && !m_held;
    exp_ifv = m_held || (exp_req && !m_drop && imem_ack && !kill);
    check_val("m_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check_val("m_addr", imem_addr, m_pc);
    check_val("m_if_valid", 32'(if_valid), 32'(exp_ifv));
    if (exp_ifv) check_val("m_if_pc", if_pc, m_pc);
    check_val("m_pc", pc, m_pc);
    check_val("m_pc_next", pc_next, m_pc + 32'd4);
    check_val("m_timeout", 32'(fetch_timeout), 32'(m_to));
  endtask

  function automatic void model_update();
    bit          kill, req;
    logic [31:0] tgt;
    if (rst) begin
      model_reset();
      return;
    end
    kill = exc_valid | redirect_valid;
    tgt  = exc_valid ? 32'h80 : {redirect_pc[31:2], 2'b00};
    req  = !m_boot && !m_held;
    if (req && !imem_ack) begin
      m_wait++;
      if (m_wait >= ACK_TO) m_to = 1'b1;
    end else if (req && imem_ack) begin
      m_wait = 0;
    end
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_held) begin
      if (kill) begin
        m_pc = tgt; m_held = 1'b0;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4; m_held = 1'b0;
      end
    end else if (m_drop) begin
      if (imem_ack) begin
        m_pc = kill ? tgt : m_tgt; m_drop = 1'b0;
      end else if (kill) begin
        m_tgt = tgt;
      end
    end else if (kill) begin
      if (imem_ack) m_pc = tgt;
      else begin
        m_drop = 1'b1; m_tgt = tgt;
      end
    end else if (imem_ack) begin
      if (stall) m_held = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic drv(input bit r, input bit st, input bit rv, input logic [31:0] rpc,
                     input bit ex, input bit ak);
    @(negedge clk);
    rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc; exc_valid = ex; imem_ack = ak;
    #1;
    compare_model();
  endtask

  task automatic edge_upd();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input bit r, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit ex, input bit ak);
    drv(r, st, rv, rpc, ex, ak);
    edge_upd();
  endtask

  initial begin
    int ack_pct;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    exc_valid = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state / BOOT cycle
    drv(0, 0, 0, 0, 0, 1);
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_req", 32'(imem_req), 32'h0);
    check_val("rst_if_valid", 32'(if_valid), 32'h0);
    check_val("rst_timeout", 32'(fetch_timeout), 32'h0);
    edge_upd();

    // Back-to-back fetch
    drv(0, 0, 0, 0, 0, 1);
    check_val("seq_addr0", imem_addr, 32'h0);
    check_val("seq_ifv0", 32'(if_valid), 32'h1);
    edge_upd();
    drv(0, 0, 0, 0, 0, 1);
    check_val("seq_addr4", imem_addr, 32'h4);
    edge_upd();

    // Stall while holding the instruction at 0x8
    drv(0, 1, 0, 0, 0, 1);
    check_val("hold_ack_addr", imem_addr, 32'h8);
    edge_upd();
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0, 0, 0);
      check_val("hold_req", 32'(imem_req), 32'h0);
      check_val("hold_if_pc", if_pc, 32'h8);
      edge_upd();
    end
    step(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    check_val("after_hold_addr", imem_addr, 32'hC);
    edge_upd();

    // Redirect kills an unacked fetch at 0x10
    drv(0, 0, 1, 32'h43, 0, 0);
    check_val("kill_addr", imem_addr, 32'h10);
    edge_upd();
    drv(0, 0, 0, 0, 0, 0);
    check_val("drop_addr", imem_addr, 32'h10);
    edge_upd();
    drv(0, 0, 0, 0, 0, 1);
    check_val("drop_ifv", 32'(if_valid), 32'h0);
    edge_upd();
    drv(0, 0, 0, 0, 0, 0);
    check_val("redir_addr", imem_addr, 32'h40);
    edge_upd();

    // Exception beats redirect on the same ack
    drv(0, 0, 1, 32'h200, 1, 1);
    check_val("exc_ifv", 32'(if_valid), 32'h0);
    edge_upd();
    drv(0, 0, 0, 0, 0, 0);
    check_val("exc_addr", imem_addr, 32'h80);
    edge_upd();

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFE, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    check_val("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check_val("wrap_pc_next", pc_next, 32'h0);
    edge_upd();
    drv(0, 0, 0, 0, 0, 0);
    check_val("wrap_next_addr", imem_addr, 32'h0);
    edge_upd();

    // Ack timeout: 15 waits stay clear, the 16th sets the sticky flag
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < ACK_TO - 1; i++) step(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    check_val("to_before", 32'(fetch_timeout), 32'h0);
    edge_upd();
    drv(0, 0, 0, 0, 0, 1);
    check_val("to_set", 32'(fetch_timeout), 32'h1);
    edge_upd();
    drv(0, 0, 1, 32'h100, 0, 0);
    check_val("to_sticky", 32'(fetch_timeout), 32'h1);
    edge_upd();
    step(1, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    check_val("rst_drop_pc", pc, 32'h0);
    check_val("rst_drop_req", 32'(imem_req), 32'h0);
    check_val("rst_drop_to", 32'(fetch_timeout), 32'h0);
    edge_upd();

    // Randomized traffic
    ack_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      bit          r, st, rv, ex, ak;
      logic [31:0] rpc;
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 90;
          1:       ack_pct = 50;
          default: ack_pct = 3;
        endcase
      end
      r   = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 7) == 0);
      ex  = ($urandom_range(0, 15) == 0);
      ak  = ($urandom_range(0, 99) < ack_pct);
      rpc = $urandom;
      step(r, st, rv, rpc, ex, ak);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
